// File: rtl/multi_dataflow_package.sv
// Shared types and constants for the multi_dataflow HWPE control path.
// Streamer, engine and FSM control/flag structs used by the sequencer.
package multi_dataflow_package;

   localparam int unsigned FSM_TIMEOUT_DEFAULT = 65535;

   typedef enum logic [2:0] {
      FSM_IDLE,
      FSM_START,
      FSM_COMPUTE,
      FSM_WAIT,
      FSM_UPDATEIDX,
      FSM_TERMINATE
   } state_fsm_t;

   typedef struct packed {
      logic [31:0] trans_size;
      logic [15:0] line_stride;
      logic [15:0] line_length;
      logic [15:0] feat_stride;
      logic [15:0] feat_length;
      logic [15:0] step;
   } stream_geom_t;

   typedef struct packed {
      logic [31:0]  base_addr;
      stream_geom_t geom;
   } addressgen_ctrl_t;

   typedef struct packed {
      logic             req_start;
      addressgen_ctrl_t addressgen_ctrl;
   } ctrl_sourcesink_t;

   typedef struct packed {
      logic ready_start;
      logic done;
   } flags_sourcesink_t;

   typedef struct packed {
      ctrl_sourcesink_t inStream0_source_ctrl;
      ctrl_sourcesink_t outStream0_sink_ctrl;
   } ctrl_streamer_t;

   typedef struct packed {
      flags_sourcesink_t inStream0_source_flags;
      flags_sourcesink_t outStream0_sink_flags;
   } flags_streamer_t;

   typedef struct packed {
      logic        clear;
      logic        enable;
      logic        start;
      logic [31:0] cnt_limit_outStream0;
      logic [15:0] width;
      logic [15:0] height;
   } ctrl_engine_t;

   typedef struct packed {
      logic done;
   } flags_engine_t;

   typedef struct packed {
      stream_geom_t inStream0_geom;
      stream_geom_t outStream0_geom;
      logic [31:0]  cnt_limit_outStream0;
      logic [15:0]  width;
      logic [15:0]  height;
   } ctrl_fsm_t;

   typedef struct packed {
      logic [15:0] nb_iter;
      logic [31:0] tile_stride;
   } ctrl_tile_t;

endpackage

// File: rtl/multi_dataflow_tile_cnt.sv
// Tile index and base-offset accumulator with last-tile detection.
// clr_i restarts the job at tile 0 / offset 0; en_i advances by one tile.
module multi_dataflow_tile_cnt
   import multi_dataflow_package::*;
(
   input  logic        clk_i,
   input  logic        clr_i,
   input  logic        en_i,
   input  ctrl_tile_t  tile_i,
   output logic [15:0] idx_o,
   output logic [31:0] offset_o,
   output logic        last_o
);

   logic [15:0] idx_q, idx_d;
   logic [31:0] offset_q, offset_d;

   always_comb begin
      idx_d    = idx_q;
      offset_d = offset_q;
      if (clr_i) begin
         idx_d    = '0;
         offset_d = '0;
      end else if (en_i) begin
         idx_d    = idx_q + 16'd1;
         offset_d = offset_q + tile_i.tile_stride;
      end
   end

   always_ff @(posedge clk_i) begin
      idx_q    <= idx_d;
      offset_q <= offset_d;
   end

   assign idx_o    = idx_q;
   assign offset_o = offset_q;
   // Compared against the index before the increment in UPDATEIDX.
   assign last_o   = ((idx_q + 16'd1) == tile_i.nb_iter);

endmodule

// File: rtl/multi_dataflow_fsm.sv
// Job sequencer: runs nb_iter tiles through source, sink and engine.
// Optional per-tile watchdog enabled by MULTI_DATAFLOW_FSM_TIMEOUT_EN.
module multi_dataflow_fsm
   import multi_dataflow_package::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = FSM_TIMEOUT_DEFAULT
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            clear_i,
   input  logic            trigger_i,
   input  logic [15:0]     nb_iter_i,
   input  logic [31:0]     tile_stride_i,
   input  logic [31:0]     base_in_i,
   input  logic [31:0]     base_out_i,
   input  ctrl_fsm_t       ctrl_fsm_i,
   input  flags_engine_t   flags_engine_i,
   input  flags_streamer_t flags_streamer_i,
   output ctrl_engine_t    ctrl_engine_o,
   output ctrl_streamer_t  ctrl_streamer_o,
   output logic            busy_o,
   output logic            done_o,
   output logic            err_o,
   output logic [15:0]     iter_idx_o
);

   state_fsm_t  state_q, state_d;
   logic [15:0] nb_iter_q, nb_iter_d;
   logic        sink_done_q, sink_done_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic        soft_rst, start_go, timeout;
   logic        tile_clr, tile_en, tile_last;
   logic [31:0] tile_offset;
   ctrl_tile_t  tile;

   assign soft_rst = rst_i | clear_i;
   assign start_go = (state_q == FSM_START)
                   & flags_streamer_i.inStream0_source_flags.ready_start
                   & flags_streamer_i.outStream0_sink_flags.ready_start;

`ifdef MULTI_DATAFLOW_FSM_TIMEOUT_EN
   logic [31:0] wdog_q, wdog_d;

   always_comb begin
      wdog_d  = wdog_q;
      timeout = 1'b0;
      if (state_q == FSM_START) begin
         wdog_d = '0;
      end else if (state_q == FSM_COMPUTE || state_q == FSM_WAIT) begin
         wdog_d  = wdog_q + 32'd1;
         timeout = (wdog_d == 32'(TIMEOUT_CYCLES));
      end
   end

   always_ff @(posedge clk_i) begin
      if (soft_rst) wdog_q <= '0;
      else          wdog_q <= wdog_d;
   end
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      nb_iter_d   = nb_iter_q;
      sink_done_d = sink_done_q;
      done_d      = 1'b0;
      err_d       = err_q;
      tile_clr    = 1'b0;
      tile_en     = 1'b0;
      case (state_q)
         FSM_IDLE: begin
            if (trigger_i) begin
               err_d = 1'b0;
               if (nb_iter_i != 16'd0) begin
                  state_d   = FSM_START;
                  nb_iter_d = nb_iter_i;
                  tile_clr  = 1'b1;
               end else begin
                  state_d = FSM_TERMINATE;
               end
            end
         end
         FSM_START: begin
            if (start_go) begin
               sink_done_d = 1'b0;
               state_d     = FSM_COMPUTE;
            end
         end
         FSM_COMPUTE: begin
            if (flags_streamer_i.outStream0_sink_flags.done) sink_done_d = 1'b1;
            if (timeout) begin
               err_d   = 1'b1;
               state_d = FSM_TERMINATE;
            end else if (flags_engine_i.done) begin
               state_d = FSM_WAIT;
            end
         end
         FSM_WAIT: begin
            if (flags_streamer_i.outStream0_sink_flags.done) sink_done_d = 1'b1;
            if (timeout) begin
               err_d   = 1'b1;
               state_d = FSM_TERMINATE;
            end else if (sink_done_q) begin
               state_d = FSM_UPDATEIDX;
            end
         end
         FSM_UPDATEIDX: begin
            tile_en = 1'b1;
            state_d = tile_last ? FSM_TERMINATE : FSM_START;
         end
         FSM_TERMINATE: begin
            done_d  = 1'b1;
            state_d = FSM_IDLE;
         end
         default: state_d = FSM_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (soft_rst) begin
         state_q     <= FSM_IDLE;
         nb_iter_q   <= '0;
         sink_done_q <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         nb_iter_q   <= nb_iter_d;
         sink_done_q <= sink_done_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   // The stride is taken live so the register file may retune it between tiles.
   assign tile.nb_iter     = nb_iter_q;
   assign tile.tile_stride = tile_stride_i;

   multi_dataflow_tile_cnt u_tile_cnt (
      .clk_i    (clk_i),
      .clr_i    (tile_clr | soft_rst),
      .en_i     (tile_en),
      .tile_i   (tile),
      .idx_o    (iter_idx_o),
      .offset_o (tile_offset),
      .last_o   (tile_last)
   );

   always_comb begin
      ctrl_engine_o.clear                = soft_rst | (state_q == FSM_UPDATEIDX);
      ctrl_engine_o.enable               = (state_q == FSM_COMPUTE);
      ctrl_engine_o.start                = start_go;
      ctrl_engine_o.cnt_limit_outStream0 = ctrl_fsm_i.cnt_limit_outStream0;
      ctrl_engine_o.width                = ctrl_fsm_i.width;
      ctrl_engine_o.height               = ctrl_fsm_i.height;

      ctrl_streamer_o.inStream0_source_ctrl.req_start                 = start_go;
      ctrl_streamer_o.inStream0_source_ctrl.addressgen_ctrl.base_addr = base_in_i + tile_offset;
      ctrl_streamer_o.inStream0_source_ctrl.addressgen_ctrl.geom      = ctrl_fsm_i.inStream0_geom;
      ctrl_streamer_o.outStream0_sink_ctrl.req_start                  = start_go;
      ctrl_streamer_o.outStream0_sink_ctrl.addressgen_ctrl.base_addr  = base_out_i + tile_offset;
      ctrl_streamer_o.outStream0_sink_ctrl.addressgen_ctrl.geom       = ctrl_fsm_i.outStream0_geom;
   end

   assign busy_o = (state_q != FSM_IDLE);
   assign done_o = done_q;
   assign err_o  = err_q;

endmodule

// File: tb/tb_multi_dataflow_fsm.sv
// Directed bench for multi_dataflow_fsm: multi-tile job, empty job, WAIT
// timing, start back-pressure, mid-job clear and the optional watchdog.
module tb_multi_dataflow_fsm;
   import multi_dataflow_package::*;

   logic            clk_i = 1'b0;
   logic            rst_i, clear_i, trigger_i;
   logic [15:0]     nb_iter_i;
   logic [31:0]     tile_stride_i, base_in_i, base_out_i;
   ctrl_fsm_t       ctrl_fsm_i;
   flags_engine_t   flags_engine_i;
   flags_streamer_t flags_streamer_i;
   ctrl_engine_t    ctrl_engine_o;
   ctrl_streamer_t  ctrl_streamer_o;
   logic            busy_o, done_o, err_o;
   logic [15:0]     iter_idx_o;

   int checks = 0, failures = 0;
   int n_req = 0, n_start = 0, n_done = 0;

   always #5 clk_i = ~clk_i;

   multi_dataflow_fsm #(.TIMEOUT_CYCLES(50)) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .clear_i          (clear_i),
      .trigger_i        (trigger_i),
      .nb_iter_i        (nb_iter_i),
      .tile_stride_i    (tile_stride_i),
      .base_in_i        (base_in_i),
      .base_out_i       (base_out_i),
      .ctrl_fsm_i       (ctrl_fsm_i),
      .flags_engine_i   (flags_engine_i),
      .flags_streamer_i (flags_streamer_i),
      .ctrl_engine_o    (ctrl_engine_o),
      .ctrl_streamer_o  (ctrl_streamer_o),
      .busy_o           (busy_o),
      .done_o           (done_o),
      .err_o            (err_o),
      .iter_idx_o       (iter_idx_o)
   );

   always @(negedge clk_i) begin
      if (rst_i === 1'b0) begin
         if (ctrl_streamer_o.inStream0_source_ctrl.req_start === 1'b1) n_req++;
         if (ctrl_engine_o.start === 1'b1) n_start++;
         if (done_o === 1'b1) n_done++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic kick(input logic [15:0] nb);
      nb_iter_i = nb;
      trigger_i = 1'b1;
      step();
      trigger_i = 1'b0;
   endtask

   task automatic wait_req(input string tag);
      int n = 0;
      while (ctrl_streamer_o.inStream0_source_ctrl.req_start !== 1'b1 && n < 30) begin
         step();
         n++;
      end
      check({tag, "_req_seen"}, 32'(ctrl_streamer_o.inStream0_source_ctrl.req_start), 32'd1);
   endtask

   // Starts in the START cycle; returns in the UPDATEIDX cycle.
   // lat = cycles from engine done to UPDATEIDX (2 means WAIT lasted one cycle).
   task automatic run_tile(input int sink_at, input int eng_at, output int lat);
      lat = -1;
      for (int k = 1; k <= 80 && lat < 0; k++) begin
         step();
         flags_streamer_i.outStream0_sink_flags.done = (k == sink_at);
         flags_engine_i.done = (k == eng_at);
         if (ctrl_engine_o.clear === 1'b1) lat = k - eng_at;
      end
      flags_streamer_i.outStream0_sink_flags.done = 1'b0;
      flags_engine_i.done = 1'b0;
   endtask

   task automatic finish_job(input string tag);
      step();
      check({tag, "_term_busy"}, 32'(busy_o), 32'd1);
      check({tag, "_term_nodone"}, 32'(done_o), 32'd0);
      step();
      check({tag, "_done"}, 32'(done_o), 32'd1);
      check({tag, "_idle_busy"}, 32'(busy_o), 32'd0);
      step();
      check({tag, "_done_1cyc"}, 32'(done_o), 32'd0);
   endtask

   task automatic run_job(input string tag, input logic [15:0] nb);
      int lat, r0, d0;
      r0 = n_req;
      d0 = n_done;
      kick(nb);
      check({tag, "_trig_to_req"}, 32'(ctrl_streamer_o.inStream0_source_ctrl.req_start), 32'd1);
      for (int t = 0; t < int'(nb); t++) begin
         wait_req(tag);
         check({tag, "_in_base"}, ctrl_streamer_o.inStream0_source_ctrl.addressgen_ctrl.base_addr,
               32'h1000 + 32'h100 * 32'(t));
         check({tag, "_out_base"}, ctrl_streamer_o.outStream0_sink_ctrl.addressgen_ctrl.base_addr,
               32'h2000 + 32'h100 * 32'(t));
         check({tag, "_iter_idx"}, 32'(iter_idx_o), 32'(t));
         check({tag, "_eng_start"}, 32'(ctrl_engine_o.start), 32'd1);
         run_tile(1, 1, lat);
         check({tag, "_tile_lat"}, 32'(lat), 32'd2);
      end
      finish_job(tag);
      check({tag, "_req_count"}, 32'(n_req - r0), 32'(nb));
      check({tag, "_done_count"}, 32'(n_done - d0), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "global timeout");
   end

   initial begin
      int lat, r0, d0, first_done, err_at_done;
      logic bad;

      rst_i = 1'b1;
      clear_i = 1'b0;
      trigger_i = 1'b0;
      nb_iter_i = '0;
      tile_stride_i = 32'h100;
      base_in_i = 32'h1000;
      base_out_i = 32'h2000;
      ctrl_fsm_i = '0;
      ctrl_fsm_i.width = 16'd28;
      ctrl_fsm_i.height = 16'd14;
      ctrl_fsm_i.cnt_limit_outStream0 = 32'd392;
      ctrl_fsm_i.outStream0_geom.line_length = 16'd7;
      flags_engine_i = '0;
      flags_streamer_i = '0;
      flags_streamer_i.inStream0_source_flags.ready_start = 1'b1;
      flags_streamer_i.outStream0_sink_flags.ready_start = 1'b1;

      // Reset state
      step();
      step();
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_done", 32'(done_o), 32'd0);
      check("rst_err", 32'(err_o), 32'd0);
      check("rst_iter", 32'(iter_idx_o), 32'd0);
      check("rst_enable", 32'(ctrl_engine_o.enable), 32'd0);
      check("rst_start", 32'(ctrl_engine_o.start), 32'd0);
      check("rst_req", 32'(ctrl_streamer_o.inStream0_source_ctrl.req_start), 32'd0);
      check("rst_eng_clear", 32'(ctrl_engine_o.clear), 32'd1);
      rst_i = 1'b0;
      #1;
      check("post_rst_clear", 32'(ctrl_engine_o.clear), 32'd0);
      check("pass_width", 32'(ctrl_engine_o.width), 32'd28);
      check("pass_cnt_limit", ctrl_engine_o.cnt_limit_outStream0, 32'd392);
      check("pass_geom", 32'(ctrl_streamer_o.outStream0_sink_ctrl.addressgen_ctrl.geom.line_length), 32'd7);
      step();

      // Three-tile job
      run_job("job3", 16'd3);
      check("start_eq_req", 32'(n_start), 32'(n_req));

      // Empty job
      r0 = n_req;
      kick(16'd0);
      check("nb0_busy", 32'(busy_o), 32'd1);
      check("nb0_nodone", 32'(done_o), 32'd0);
      step();
      check("nb0_done", 32'(done_o), 32'd1);
      check("nb0_idle", 32'(busy_o), 32'd0);
      step();
      check("nb0_done_1cyc", 32'(done_o), 32'd0);
      check("nb0_no_req", 32'(n_req - r0), 32'd0);

      // Sink done well before engine done, then both together
      kick(16'd1);
      wait_req("early_sink");
      run_tile(1, 6, lat);
      check("early_sink_wait1", 32'(lat), 32'd2);
      finish_job("early_sink");
      kick(16'd1);
      wait_req("same_cyc");
      run_tile(3, 3, lat);
      check("same_cyc_wait1", 32'(lat), 32'd2);
      finish_job("same_cyc");

      // Source not ready for 10 cycles in START
      r0 = n_req;
      flags_streamer_i.inStream0_source_flags.ready_start = 1'b0;
      kick(16'd1);
      bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (ctrl_streamer_o.inStream0_source_ctrl.req_start !== 1'b0) bad = 1'b1;
         if (ctrl_engine_o.start !== 1'b0) bad = 1'b1;
         step();
      end
      check("notready_no_req", 32'(bad), 32'd0);
      check("notready_busy", 32'(busy_o), 32'd1);
      flags_streamer_i.inStream0_source_flags.ready_start = 1'b1;
      #1;
      check("ready_req", 32'(ctrl_streamer_o.inStream0_source_ctrl.req_start), 32'd1);
      run_tile(1, 1, lat);
      finish_job("notready");
      check("notready_one_req", 32'(n_req - r0), 32'd1);

      // Clear during COMPUTE of tile 1
      d0 = n_done;
      kick(16'd3);
      run_tile(1, 1, lat);
      wait_req("clr");
      check("clr_iter1", 32'(iter_idx_o), 32'd1);
      check("clr_base1", ctrl_streamer_o.inStream0_source_ctrl.addressgen_ctrl.base_addr, 32'h1100);
      step();
      check("clr_in_compute", 32'(ctrl_engine_o.enable), 32'd1);
      clear_i = 1'b1;
      step();
      clear_i = 1'b0;
      check("clr_idle", 32'(busy_o), 32'd0);
      check("clr_iter0", 32'(iter_idx_o), 32'd0);
      check("clr_enable", 32'(ctrl_engine_o.enable), 32'd0);
      step();
      step();
      step();
      check("clr_no_done", 32'(n_done - d0), 32'd0);
      run_job("restart", 16'd3);

      // Watchdog: engine never finishes
      kick(16'd1);
      wait_req("wdog");
      first_done = -1;
      err_at_done = 0;
      for (int k = 1; k <= 60; k++) begin
         step();
         if (done_o === 1'b1 && first_done < 0) begin
            first_done = k;
            err_at_done = int'(err_o);
         end
      end
`ifdef MULTI_DATAFLOW_FSM_TIMEOUT_EN
      check("wdog_done_at", 32'(first_done), 32'd52);
      check("wdog_err", 32'(err_at_done), 32'd1);
      check("wdog_err_sticky", 32'(err_o), 32'd1);
      check("wdog_idle", 32'(busy_o), 32'd0);
      kick(16'd0);
      check("wdog_err_cleared", 32'(err_o), 32'd0);
      step();
      step();
`else
      check("wdog_no_done", 32'(first_done + 1), 32'd0);
      check("wdog_still_busy", 32'(busy_o), 32'd1);
      check("wdog_still_compute", 32'(ctrl_engine_o.enable), 32'd1);
      check("wdog_no_err", 32'(err_o), 32'd0);
      clear_i = 1'b1;
      step();
      clear_i = 1'b0;
      check("wdog_cleared", 32'(busy_o), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
